// File: rtl/r2s_frame_tracker.sv
`default_nettype none
// ============================================================================
// Module   : r2s_frame_tracker
// Purpose  : Tracks DCD row/frame timing from row2sync and frame-sync strobes;
//            counts rows, measures row2sync period, flags sticky errors and
//            pulses ROW_MATCH at a selected row. Optional period bound check
//            is enabled by defining R2S_PERIOD_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module r2s_frame_tracker #(
  parameter int ROW_WIDTH     = 10,
  parameter int PERIOD_WIDTH  = 16,
  parameter int EXPECTED_ROWS = 192,
  parameter int TIMEOUT       = 4096
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    R2S_STROBE,
  input  logic                    FSYNC_STROBE,
  input  logic [ROW_WIDTH-1:0]    ROW_SEL,
  input  logic [PERIOD_WIDTH-1:0] PERIOD_MIN,
  input  logic [PERIOD_WIDTH-1:0] PERIOD_MAX,
  input  logic                    CLEAR_ERR,
  output logic                    SYNCED,
  output logic [ROW_WIDTH-1:0]    ROW_CNT,
  output logic [ROW_WIDTH-1:0]    ROWS_LAST,
  output logic [15:0]             FRAME_CNT,
  output logic [PERIOD_WIDTH-1:0] R2S_PERIOD,
  output logic                    ROW_MATCH,
  output logic                    ROW_ERR,
  output logic                    PERIOD_ERR,
  output logic                    LOST_ERR
);

  localparam logic [ROW_WIDTH-1:0]    c_rows_expected = ROW_WIDTH'(EXPECTED_ROWS);
  localparam logic [PERIOD_WIDTH-1:0] c_timeout_last  = PERIOD_WIDTH'(TIMEOUT - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                  r_state;
  logic [ROW_WIDTH-1:0]    r_row_cnt;
  logic [ROW_WIDTH-1:0]    r_rows_last;
  logic [15:0]             r_frame_cnt;
  logic [PERIOD_WIDTH-1:0] r_period;
  logic [PERIOD_WIDTH-1:0] r_period_cnt;
  logic [PERIOD_WIDTH-1:0] r_idle_cnt;
  logic                    r_row_match;
  logic                    r_row_err;
  logic                    r_lost_err;
  logic                    r_r2s_seen;

  logic                    w_run;
  logic                    w_strobe;
  logic                    w_timeout;
  logic                    w_period_upd;
  logic [ROW_WIDTH-1:0]    w_row_base;

  always_comb begin
    w_run        = (r_state == ST_RUN);
    w_strobe     = R2S_STROBE | FSYNC_STROBE;
    // A strobe in the expiry cycle keeps the link alive.
    w_timeout    = w_run & ~w_strobe & (r_idle_cnt == c_timeout_last);
    w_period_upd = w_run & R2S_STROBE & r_r2s_seen;
    // A coincident frame-sync starts the new frame before the row is counted.
    w_row_base   = FSYNC_STROBE ? '0 : r_row_cnt;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state      <= ST_IDLE;
      r_row_cnt    <= '0;
      r_rows_last  <= '0;
      r_frame_cnt  <= '0;
      r_period     <= '0;
      r_period_cnt <= '0;
      r_idle_cnt   <= '0;
      r_row_match  <= 1'b0;
      r_row_err    <= 1'b0;
      r_lost_err   <= 1'b0;
      r_r2s_seen   <= 1'b0;
    end else begin
      r_row_match <= 1'b0;
      if (CLEAR_ERR) begin
        r_row_err  <= 1'b0;
        r_lost_err <= 1'b0;
      end
      case (r_state)
        ST_IDLE: begin
          r_idle_cnt   <= '0;
          r_period_cnt <= '0;
          if (FSYNC_STROBE) begin
            r_state    <= ST_RUN;
            r_row_cnt  <= '0;
            r_r2s_seen <= 1'b0;
          end
        end
        ST_RUN: begin
          if (w_timeout) begin
            r_state      <= ST_IDLE;
            r_row_cnt    <= '0;
            r_lost_err   <= 1'b1;
            r_idle_cnt   <= '0;
            r_period_cnt <= '0;
          end else begin
            if (w_strobe)
              r_idle_cnt <= '0;
            else if (r_idle_cnt != '1)
              r_idle_cnt <= r_idle_cnt + 1'b1;

            if (FSYNC_STROBE) begin
              r_rows_last <= r_row_cnt;
              r_frame_cnt <= r_frame_cnt + 16'd1;
              if (r_row_cnt != c_rows_expected)
                r_row_err <= 1'b1;
            end

            if (R2S_STROBE) begin
              r_row_cnt    <= (w_row_base == '1) ? w_row_base : w_row_base + 1'b1;
              r_row_match  <= (w_row_base == ROW_SEL);
              r_period_cnt <= PERIOD_WIDTH'(1);
              r_r2s_seen   <= 1'b1;
              if (w_period_upd)
                r_period <= r_period_cnt;
            end else begin
              r_row_cnt <= w_row_base;
              if (r_period_cnt != '1)
                r_period_cnt <= r_period_cnt + 1'b1;
            end
          end
        end
      endcase
    end
  end

`ifdef R2S_PERIOD_CHECK_EN
  logic r_period_err;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)
      r_period_err <= 1'b0;
    else if (w_period_upd && ((r_period_cnt < PERIOD_MIN) || (r_period_cnt > PERIOD_MAX)))
      r_period_err <= 1'b1;
    else if (CLEAR_ERR)
      r_period_err <= 1'b0;
  end

  assign PERIOD_ERR = r_period_err;
`else
  logic w_unused;
  assign w_unused   = ^{PERIOD_MIN, PERIOD_MAX};
  assign PERIOD_ERR = 1'b0;
`endif

  assign SYNCED     = (r_state == ST_RUN);
  assign ROW_CNT    = r_row_cnt;
  assign ROWS_LAST  = r_rows_last;
  assign FRAME_CNT  = r_frame_cnt;
  assign R2S_PERIOD = r_period;
  assign ROW_MATCH  = r_row_match;
  assign ROW_ERR    = r_row_err;
  assign LOST_ERR   = r_lost_err;

endmodule
`default_nettype wire
